// File: rtl/iexec_mem_latch.sv
// EX/MEM pipeline latch: captures execute results, owns the data-memory request
// handshake and back-pressures upstream stages. Optional perf counters under EXMEM_PERF_EN.
module iexec_mem_latch #(
    parameter int WORD_W = 32,
    parameter int REG_W  = 5
`ifdef EXMEM_PERF_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              flush,
    input  logic [WORD_W-1:0] aluout_in,
    input  logic [WORD_W-1:0] rdat2_in,
    input  logic [WORD_W-1:0] pcplusfour_in,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [REG_W-1:0]  wsel_in,
    input  logic              dREN_in,
    input  logic              dWEN_in,
    input  logic              RegWr_in,
    input  logic              MemtoReg_in,
    input  logic              jal_s_in,
    input  logic              halt_in,
    input  logic [WORD_W-1:0] dmemload,
    output logic [WORD_W-1:0] aluout_out,
    output logic [WORD_W-1:0] rdat2_out,
    output logic [WORD_W-1:0] pcplusfour_out,
    output logic [WORD_W-1:0] instr_out,
    output logic [REG_W-1:0]  wsel_out,
    output logic              dREN_out,
    output logic              dWEN_out,
    output logic              RegWr_out,
    output logic              MemtoReg_out,
    output logic              jal_s_out,
    output logic              halt_out,
    output logic [WORD_W-1:0] dmemaddr,
    output logic [WORD_W-1:0] dmemstore,
    output logic [WORD_W-1:0] dload_out,
`ifdef EXMEM_PERF_EN
    output logic [CNT_W-1:0]  instr_cnt,
    output logic [CNT_W-1:0]  mem_stall_cnt,
`endif
    output logic              mem_busy
);

    // state | meaning
    // IDLE  | no memory op in latch
    // REQ   | dREN_out/dWEN_out asserted, waiting on dhit
    // DONE  | access served, waiting for pipeline advance
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t state, state_next;
    logic   advance;
    logic   bubble;
    logic   load_mem_op;

    assign advance     = ihit && (state != REQ);
    // Once halted, the latch only ever takes bubbles until reset.
    assign bubble      = flush || halt_out;
    assign load_mem_op = !bubble && (dREN_in || dWEN_in);
    assign mem_busy    = (state == REQ);
    assign dmemaddr    = aluout_out;
    assign dmemstore   = rdat2_out;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            REQ: begin
                if (dhit) begin
                    state_next = DONE;
                end
            end
            default: begin
                if (advance) begin
                    state_next = load_mem_op ? REQ : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            aluout_out     <= '0;
            rdat2_out      <= '0;
            pcplusfour_out <= '0;
            instr_out      <= '0;
            wsel_out       <= '0;
            dREN_out       <= 1'b0;
            dWEN_out       <= 1'b0;
            RegWr_out      <= 1'b0;
            MemtoReg_out   <= 1'b0;
            jal_s_out      <= 1'b0;
            halt_out       <= 1'b0;
            dload_out      <= '0;
        end else if (advance) begin
            if (bubble) begin
                aluout_out     <= '0;
                rdat2_out      <= '0;
                pcplusfour_out <= '0;
                instr_out      <= '0;
                wsel_out       <= '0;
                dREN_out       <= 1'b0;
                dWEN_out       <= 1'b0;
                RegWr_out      <= 1'b0;
                MemtoReg_out   <= 1'b0;
                jal_s_out      <= 1'b0;
            end else begin
                aluout_out     <= aluout_in;
                rdat2_out      <= rdat2_in;
                pcplusfour_out <= pcplusfour_in;
                instr_out      <= instr_in;
                wsel_out       <= wsel_in;
                dREN_out       <= dREN_in;
                dWEN_out       <= dWEN_in;
                RegWr_out      <= RegWr_in;
                MemtoReg_out   <= MemtoReg_in;
                jal_s_out      <= jal_s_in;
                halt_out       <= halt_in;
            end
        end else if ((state == REQ) && dhit) begin
            if (dREN_out) begin
                dload_out <= dmemload;
            end
            dREN_out <= 1'b0;
            dWEN_out <= 1'b0;
        end
    end

`ifdef EXMEM_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            instr_cnt     <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (advance && !bubble && (instr_cnt != '1)) begin
                instr_cnt <= instr_cnt + 1'b1;
            end
            if ((state == REQ) && (mem_stall_cnt != '1)) begin
                mem_stall_cnt <= mem_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_iexec_mem_latch.sv
// Bench for iexec_mem_latch: directed vector table, hand sequences for halt and async
// reset, then random traffic against a transaction-level reference model.
module tb_iexec_mem_latch;

    logic        CLK, RST;
    logic        ihit, dhit, flush;
    logic [31:0] aluout_in, rdat2_in, pcplusfour_in, instr_in, dmemload;
    logic [4:0]  wsel_in;
    logic        dREN_in, dWEN_in, RegWr_in, MemtoReg_in, jal_s_in, halt_in;
    logic [31:0] aluout_out, rdat2_out, pcplusfour_out, instr_out, dmemaddr, dmemstore, dload_out;
    logic [4:0]  wsel_out;
    logic        dREN_out, dWEN_out, RegWr_out, MemtoReg_out, jal_s_out, halt_out, mem_busy;
`ifdef EXMEM_PERF_EN
    logic [31:0] instr_cnt, mem_stall_cnt;
`endif

    iexec_mem_latch dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .flush(flush),
        .aluout_in(aluout_in), .rdat2_in(rdat2_in), .pcplusfour_in(pcplusfour_in),
        .instr_in(instr_in), .wsel_in(wsel_in), .dREN_in(dREN_in), .dWEN_in(dWEN_in),
        .RegWr_in(RegWr_in), .MemtoReg_in(MemtoReg_in), .jal_s_in(jal_s_in),
        .halt_in(halt_in), .dmemload(dmemload),
        .aluout_out(aluout_out), .rdat2_out(rdat2_out), .pcplusfour_out(pcplusfour_out),
        .instr_out(instr_out), .wsel_out(wsel_out), .dREN_out(dREN_out),
        .dWEN_out(dWEN_out), .RegWr_out(RegWr_out), .MemtoReg_out(MemtoReg_out),
        .jal_s_out(jal_s_out), .halt_out(halt_out), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .dload_out(dload_out),
`ifdef EXMEM_PERF_EN
        .instr_cnt(instr_cnt), .mem_stall_cnt(mem_stall_cnt),
`endif
        .mem_busy(mem_busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: latch contents plus an "op outstanding" flag.
    logic [31:0] m_alu, m_rdat2, m_pc4, m_instr, m_dload, m_icnt, m_scnt;
    logic [4:0]  m_wsel;
    logic        m_ren, m_wen, m_regwr, m_m2r, m_jal, m_halt, m_pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_alu = 0; m_rdat2 = 0; m_pc4 = 0; m_instr = 0; m_dload = 0; m_wsel = 0;
        m_ren = 0; m_wen = 0; m_regwr = 0; m_m2r = 0; m_jal = 0; m_halt = 0;
        m_pending = 0; m_icnt = 0; m_scnt = 0;
    endtask

    task automatic model_step();
        logic adv, bub;
        adv = ihit && !m_pending;
        bub = flush || m_halt;
        if (m_pending && m_scnt != 32'hFFFF_FFFF) m_scnt++;
        if (adv) begin
            if (!bub && m_icnt != 32'hFFFF_FFFF) m_icnt++;
            if (bub) begin
                m_alu = 0; m_rdat2 = 0; m_pc4 = 0; m_instr = 0; m_wsel = 0;
                m_ren = 0; m_wen = 0; m_regwr = 0; m_m2r = 0; m_jal = 0;
            end else begin
                m_alu = aluout_in; m_rdat2 = rdat2_in; m_pc4 = pcplusfour_in;
                m_instr = instr_in; m_wsel = wsel_in; m_ren = dREN_in; m_wen = dWEN_in;
                m_regwr = RegWr_in; m_m2r = MemtoReg_in; m_jal = jal_s_in; m_halt = halt_in;
            end
            m_pending = m_ren || m_wen;
        end else if (m_pending && dhit) begin
            if (m_ren) m_dload = dmemload;
            m_ren = 0;
            m_wen = 0;
            m_pending = 0;
        end
    endtask

    task automatic compare_all();
        chk("aluout_out", aluout_out, m_alu);
        chk("rdat2_out", rdat2_out, m_rdat2);
        chk("pcplusfour_out", pcplusfour_out, m_pc4);
        chk("instr_out", instr_out, m_instr);
        chk("wsel_out", {27'd0, wsel_out}, {27'd0, m_wsel});
        chk("dREN_out", {31'd0, dREN_out}, {31'd0, m_ren});
        chk("dWEN_out", {31'd0, dWEN_out}, {31'd0, m_wen});
        chk("RegWr_out", {31'd0, RegWr_out}, {31'd0, m_regwr});
        chk("MemtoReg_out", {31'd0, MemtoReg_out}, {31'd0, m_m2r});
        chk("jal_s_out", {31'd0, jal_s_out}, {31'd0, m_jal});
        chk("halt_out", {31'd0, halt_out}, {31'd0, m_halt});
        chk("dmemaddr", dmemaddr, m_alu);
        chk("dmemstore", dmemstore, m_rdat2);
        chk("dload_out", dload_out, m_dload);
        chk("mem_busy", {31'd0, mem_busy}, {31'd0, m_pending});
`ifdef EXMEM_PERF_EN
        chk("instr_cnt", instr_cnt, m_icnt);
        chk("mem_stall_cnt", mem_stall_cnt, m_scnt);
`endif
    endtask

    // Inputs are driven 1 time unit after an edge; tick advances one clock and checks.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        ihit = 0; dhit = 0; flush = 0; aluout_in = 0; rdat2_in = 0; pcplusfour_in = 0;
        instr_in = 0; wsel_in = 0; dREN_in = 0; dWEN_in = 0; RegWr_in = 0;
        MemtoReg_in = 0; jal_s_in = 0; halt_in = 0; dmemload = 0;
    endtask

    // Asynchronous reset pulse in the middle of a cycle, checked before the next edge.
    task automatic async_reset();
        @(posedge CLK);
        #3;
        RST = 1;
        model_reset();
        #1;
        compare_all();
        chk("async_rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("async_rst_dren", {31'd0, dREN_out}, 32'd0);
        @(negedge CLK);
        RST = 0;
    endtask

    typedef struct {
        logic        ihit, dhit, flush;
        logic [31:0] alu;
        logic [4:0]  wsel;
        logic        dren, dwen, regwr;
        logic [31:0] dml;
        logic [31:0] e_alu;
        logic [4:0]  e_wsel;
        logic        e_dren, e_dwen, e_regwr, e_busy;
        logic [31:0] e_dload;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1, 0, 0, 32'h10, 5, 0, 0, 1, 0,            32'h10, 5, 0, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 0, 32'h40, 8, 1, 0, 1, 0,            32'h40, 8, 1, 0, 1, 1, 0};
        tbl[2]  = '{1, 0, 0, 32'h99, 3, 0, 0, 0, 0,            32'h40, 8, 1, 0, 1, 1, 0};
        tbl[3]  = '{1, 0, 0, 32'h99, 3, 0, 0, 0, 0,            32'h40, 8, 1, 0, 1, 1, 0};
        tbl[4]  = '{1, 1, 0, 32'h99, 3, 0, 0, 0, 32'hDEADBEEF, 32'h40, 8, 0, 0, 1, 0, 32'hDEADBEEF};
        tbl[5]  = '{1, 0, 0, 32'h99, 3, 0, 0, 0, 0,            32'h99, 3, 0, 0, 0, 0, 32'hDEADBEEF};
        tbl[6]  = '{1, 0, 0, 32'h80, 0, 0, 1, 0, 0,            32'h80, 0, 0, 1, 0, 1, 32'hDEADBEEF};
        tbl[7]  = '{1, 0, 1, 32'h11, 0, 0, 0, 0, 0,            32'h80, 0, 0, 1, 0, 1, 32'hDEADBEEF};
        tbl[8]  = '{0, 1, 0, 32'h11, 0, 0, 0, 0, 32'h1234,     32'h80, 0, 0, 0, 0, 0, 32'hDEADBEEF};
        tbl[9]  = '{1, 0, 1, 32'h55, 7, 1, 0, 1, 0,            0,      0, 0, 0, 0, 0, 32'hDEADBEEF};
        tbl[10] = '{0, 0, 0, 32'h66, 7, 0, 0, 1, 0,            0,      0, 0, 0, 0, 0, 32'hDEADBEEF};
        tbl[11] = '{0, 0, 1, 32'h77, 2, 0, 0, 1, 0,            0,      0, 0, 0, 0, 0, 32'hDEADBEEF};
        tbl[12] = '{1, 0, 0, 32'h77, 2, 0, 0, 1, 0,            32'h77, 2, 0, 0, 1, 0, 32'hDEADBEEF};

        clear_inputs();
        RST = 1;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        compare_all();
        @(negedge CLK);
        RST = 0;

        for (int i = 0; i < 13; i++) begin
            ihit = tbl[i].ihit; dhit = tbl[i].dhit; flush = tbl[i].flush;
            aluout_in = tbl[i].alu; rdat2_in = tbl[i].alu + 32'd1;
            pcplusfour_in = tbl[i].alu + 32'd4; instr_in = ~tbl[i].alu;
            wsel_in = tbl[i].wsel; dREN_in = tbl[i].dren; dWEN_in = tbl[i].dwen;
            RegWr_in = tbl[i].regwr; dmemload = tbl[i].dml;
            tick();
            chk($sformatf("vec%0d_alu", i), aluout_out, tbl[i].e_alu);
            chk($sformatf("vec%0d_wsel", i), {27'd0, wsel_out}, {27'd0, tbl[i].e_wsel});
            chk($sformatf("vec%0d_dren", i), {31'd0, dREN_out}, {31'd0, tbl[i].e_dren});
            chk($sformatf("vec%0d_dwen", i), {31'd0, dWEN_out}, {31'd0, tbl[i].e_dwen});
            chk($sformatf("vec%0d_regwr", i), {31'd0, RegWr_out}, {31'd0, tbl[i].e_regwr});
            chk($sformatf("vec%0d_busy", i), {31'd0, mem_busy}, {31'd0, tbl[i].e_busy});
            chk($sformatf("vec%0d_dload", i), dload_out, tbl[i].e_dload);
        end

        // Sticky halt: later advances load bubbles only.
        clear_inputs();
        ihit = 1; halt_in = 1; aluout_in = 32'h3;
        tick();
        chk("halt_set", {31'd0, halt_out}, 32'd1);
        halt_in = 0; RegWr_in = 1; aluout_in = 32'h5; wsel_in = 9;
        tick();
        chk("halt_sticky", {31'd0, halt_out}, 32'd1);
        chk("halt_regwr", {31'd0, RegWr_out}, 32'd0);
        chk("halt_alu", aluout_out, 32'd0);

        // Reset while a load is outstanding.
        async_reset();
        clear_inputs();
        ihit = 1; dREN_in = 1; aluout_in = 32'h40;
        tick();
        chk("pre_rst_busy", {31'd0, mem_busy}, 32'd1);
        async_reset();

        for (int i = 0; i < 600; i++) begin
            if (i % 100 == 99) begin
                async_reset();
            end
            ihit = ($urandom % 4) != 0;
            dhit = ($urandom % 3) == 0;
            flush = ($urandom % 8) == 0;
            aluout_in = $urandom; rdat2_in = $urandom; pcplusfour_in = $urandom;
            instr_in = $urandom; wsel_in = 5'($urandom); dmemload = $urandom;
            case ($urandom % 3)
                0: begin dREN_in = 1; dWEN_in = 0; end
                1: begin dREN_in = 0; dWEN_in = 1; end
                default: begin dREN_in = 0; dWEN_in = 0; end
            endcase
            RegWr_in = 1'($urandom); MemtoReg_in = 1'($urandom); jal_s_in = 1'($urandom);
            halt_in = ($urandom % 60) == 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
